rib_arb: RTL and testbench

//   Parametrised shared-bus interconnect: NUM_M masters, NUM_S slaves.
//   Per-master req/gnt handshake; round-robin or fixed-priority arbitration;

---
 rtl/rib_arb.sv | 166 ++++++++++++++++
 tb/tb_rib_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_arb.sv
// rib_arb: shared-bus interconnect for NUM_M masters and NUM_S slaves.
// Combinational grant (round-robin or fixed priority) with a bounded bus lock,
// mask/base slave decode and a one-entry registered response stage. The
// response stage carries the master tag, so a new grant can follow a read
// grant in the very next cycle.
module rib_arb #(
  parameter int                      NUM_M    = 3,
  parameter int                      NUM_S    = 4,
  parameter int                      ADDR_W   = 32,
  parameter int                      DATA_W   = 32,
  parameter logic [NUM_S*ADDR_W-1:0] S_BASE   = {32'h2000_0000, 32'h1000_0000,
                                                 32'h0000_4000, 32'h0000_0000},
  parameter logic [NUM_S*ADDR_W-1:0] S_MASK   = {32'hF000_0000, 32'hF000_0000,
                                                 32'hF000_C000, 32'hF000_C000},
  parameter bit                      RR_EN    = 1'b1,
  parameter int                      LOCK_MAX = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M-1:0]         m_req,
  input  logic [NUM_M-1:0]         m_we,
  input  logic [NUM_M-1:0]         m_lock,
  input  logic [NUM_M*ADDR_W-1:0]  m_addr,
  input  logic [NUM_M*DATA_W-1:0]  m_wdata,
  output logic [NUM_M-1:0]         m_gnt,
  output logic [NUM_M-1:0]         m_rvalid,
  output logic [NUM_M-1:0]         m_rerr,
  output logic [DATA_W-1:0]        m_rdata,
  output logic [NUM_S-1:0]         s_we,
  output logic [NUM_S-1:0]         s_re,
  output logic [NUM_S*ADDR_W-1:0]  s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic [NUM_S*DATA_W-1:0]  s_rdata
);

  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CNT_CAP = CW'(LOCK_MAX - 1);

  // arbitration / lock state
  logic [MW-1:0] ptr_q, ptr_d;
  logic          lock_vld_q, lock_vld_d;
  logic [MW-1:0] lock_own_q, lock_own_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  // response stage
  logic          rsp_vld_q, rsp_vld_d;
  logic [MW-1:0] rsp_mst_q, rsp_mst_d;
  logic [SW-1:0] rsp_sel_q, rsp_sel_d;
  logic          rsp_hit_q, rsp_hit_d;

  // current-cycle grant and decode
  logic              arb_any;
  logic [MW-1:0]     arb_w;
  logic              lock_byp;
  logic              gnt_any;
  logic [MW-1:0]     gnt_w;
  logic              we_w;
  logic [ADDR_W-1:0] addr_w;
  logic              dec_hit;
  logic [SW-1:0]     dec_sel;

  // Normal arbitration: first requester scanning from ptr (RR) or from index 0.
  always_comb begin
    int idx;
    idx     = 0;
    arb_any = 1'b0;
    arb_w   = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (RR_EN) idx = (int'(ptr_q) + k) % NUM_M;
      else       idx = k;
      if (!arb_any && m_req[MW'(idx)]) begin
        arb_any = 1'b1;
        arb_w   = MW'(idx);
      end
    end
  end

  // Lock bypass and final winner; the lowest matching slave wins the decode.
  always_comb begin
    lock_byp = lock_vld_q && m_req[lock_own_q] && (lock_cnt_q != CNT_CAP);
    gnt_w    = lock_byp ? lock_own_q : arb_w;
    gnt_any  = !rst && (lock_byp || arb_any);
    we_w     = m_we[gnt_w];
    addr_w   = m_addr[gnt_w*ADDR_W +: ADDR_W];
    dec_hit  = 1'b0;
    dec_sel  = '0;
    for (int i = 0; i < NUM_S; i++) begin
      if (!dec_hit && ((addr_w & S_MASK[i*ADDR_W +: ADDR_W]) == S_BASE[i*ADDR_W +: ADDR_W])) begin
        dec_hit = 1'b1;
        dec_sel = SW'(i);
      end
    end
  end

  // Bus-side outputs and the response returned to the tagged master.
  always_comb begin
    m_gnt    = '0;
    s_we     = '0;
    s_re     = '0;
    s_addr   = '0;
    s_wdata  = '0;
    m_rvalid = '0;
    m_rerr   = '0;
    m_rdata  = '0;
    if (gnt_any) begin
      m_gnt[gnt_w] = 1'b1;
      s_wdata      = m_wdata[gnt_w*DATA_W +: DATA_W];
      if (dec_hit) begin
        s_addr[dec_sel*ADDR_W +: ADDR_W] = addr_w & ~S_MASK[dec_sel*ADDR_W +: ADDR_W];
        if (we_w) s_we[dec_sel] = 1'b1;
        else      s_re[dec_sel] = 1'b1;
      end
    end
    if (rsp_vld_q && !rst) begin
      m_rvalid[rsp_mst_q] = 1'b1;
      if (rsp_hit_q) m_rdata = s_rdata[rsp_sel_q*DATA_W +: DATA_W];
      else           m_rerr[rsp_mst_q] = 1'b1;
    end
  end

  // Next state: pointer advance, lock tracking, response capture.
  always_comb begin
    ptr_d      = ptr_q;
    lock_vld_d = 1'b0;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    rsp_vld_d  = 1'b0;
    rsp_mst_d  = gnt_w;
    rsp_sel_d  = dec_sel;
    rsp_hit_d  = dec_hit;
    if (gnt_any) begin
      ptr_d      = (gnt_w == MW'(NUM_M - 1)) ? '0 : gnt_w + 1'b1;
      lock_vld_d = m_lock[gnt_w];
      lock_own_d = gnt_w;
      lock_cnt_d = lock_byp ? lock_cnt_q + 1'b1 : '0;
      // writes that hit complete on the bus and need no response
      rsp_vld_d  = !we_w || !dec_hit;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_cnt_q <= '0;
      rsp_vld_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_cnt_q <= lock_cnt_d;
      rsp_vld_q  <= rsp_vld_d;
    end
  end

  // Tag/data registers, qualified by the valid flags above.
  always_ff @(posedge clk) begin
    lock_own_q <= lock_own_d;
    rsp_mst_q  <= rsp_mst_d;
    rsp_sel_q  <= rsp_sel_d;
    rsp_hit_q  <= rsp_hit_d;
  end

endmodule

// File: tb/tb_rib_arb.sv
// tb_rib_arb: directed scenarios plus randomized traffic, every cycle checked
// against a behavioural model of the interconnect (round-robin DUT) and a
// fixed-priority DUT sharing the same inputs.
module tb_rib_arb;
  localparam int NM = 3;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LM = 4;
  localparam logic [NS*AW-1:0] BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_4000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_C000, 32'hF000_C000};

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req, m_we, m_lock;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM-1:0]     m_gnt, m_rvalid, m_rerr;
  logic [DW-1:0]     m_rdata;
  logic [NS-1:0]     s_we, s_re;
  logic [NS*AW-1:0]  s_addr;
  logic [DW-1:0]     s_wdata;
  logic [NS*DW-1:0]  s_rdata;
  logic [NM-1:0]     f_gnt, f_rvalid, f_rerr;
  logic [DW-1:0]     f_rdata;
  logic [NS-1:0]     f_s_we, f_s_re;
  logic [NS*AW-1:0]  f_s_addr;
  logic [DW-1:0]     f_s_wdata;

  rib_arb #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW), .S_BASE(BASE), .S_MASK(MASK),
            .RR_EN(1'b1), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_lock(m_lock), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rerr(m_rerr), .m_rdata(m_rdata),
    .s_we(s_we), .s_re(s_re), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata));

  rib_arb #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW), .S_BASE(BASE), .S_MASK(MASK),
            .RR_EN(1'b0), .LOCK_MAX(LM)) dut_fp (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_lock(m_lock), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(f_gnt), .m_rvalid(f_rvalid), .m_rerr(f_rerr), .m_rdata(f_rdata),
    .s_we(f_s_we), .s_re(f_s_re), .s_addr(f_s_addr), .s_wdata(f_s_wdata), .s_rdata(s_rdata));

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // reference model state
  int ptr    = 0;
  int lk_own = -1;
  int lk_cnt = 0;
  bit pv     = 1'b0;
  bit ph     = 1'b0;
  int pm     = 0;
  int ps     = 0;
  int cur_w, cur_s;
  bit cur_byp;

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) return i;
    return -1;
  endfunction

  function automatic logic [AW-1:0] raddr();
    logic [AW-1:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       return r & 32'h0000_3FFF;
      1:       return 32'h0000_4000 | (r & 32'h0000_0FFF);
      2:       return 32'h1000_0000 | (r & 32'h0000_FFFF);
      3:       return 32'h2000_0000 | (r & 32'h0000_FFFF);
      default: return r;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict this cycle's outputs from the model, then compare at the falling edge.
  task automatic pre();
    logic [NM-1:0]    eg, erv, eer;
    logic [NS-1:0]    ewe, ere;
    logic [NS*AW-1:0] ead;
    logic [DW-1:0]    ewd, erd;
    logic [AW-1:0]    a;
    eg = '0; erv = '0; eer = '0; ewe = '0; ere = '0; ead = '0; ewd = '0; erd = '0;
    cur_w = -1; cur_s = -1; cur_byp = 1'b0;
    if (lk_own >= 0 && m_req[lk_own] && lk_cnt < LM - 1) begin
      cur_w = lk_own; cur_byp = 1'b1;
    end else begin
      for (int k = 0; k < NM; k++) begin
        int idx;
        idx = (ptr + k) % NM;
        if (cur_w < 0 && m_req[idx]) cur_w = idx;
      end
    end
    if (cur_w >= 0) begin
      a = m_addr[cur_w*AW +: AW];
      cur_s = decode(a);
      if (!rst) begin
        eg[cur_w] = 1'b1;
        ewd = m_wdata[cur_w*DW +: DW];
        if (cur_s >= 0) begin
          ead[cur_s*AW +: AW] = a & ~MASK[cur_s*AW +: AW];
          if (m_we[cur_w]) ewe[cur_s] = 1'b1;
          else             ere[cur_s] = 1'b1;
        end
      end
    end
    if (!rst && pv) begin
      erv[pm] = 1'b1;
      if (ph) erd = s_rdata[ps*DW +: DW];
      else    eer[pm] = 1'b1;
    end
    @(negedge clk);
    chk("m_gnt", m_gnt, eg);
    chk("s_we", s_we, ewe);
    chk("s_re", s_re, ere);
    chk("s_addr", s_addr, ead);
    chk("s_wdata", s_wdata, ewd);
    chk("m_rvalid", m_rvalid, erv);
    chk("m_rerr", m_rerr, eer);
    chk("m_rdata", m_rdata, erd);
  endtask

  // Advance the model at the rising edge, then present new slave read data.
  task automatic post();
    @(posedge clk);
    if (rst) begin
      ptr = 0; lk_own = -1; lk_cnt = 0; pv = 1'b0;
    end else if (cur_w >= 0) begin
      ptr    = (cur_w + 1) % NM;
      lk_cnt = cur_byp ? lk_cnt + 1 : 0;
      lk_own = m_lock[cur_w] ? cur_w : -1;
      pv     = !m_we[cur_w] || cur_s < 0;
      pm     = cur_w;
      ps     = cur_s;
      ph     = cur_s >= 0;
    end else begin
      lk_own = -1; pv = 1'b0;
    end
    #1;
    s_rdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle();
    m_req = '0; m_we = '0; m_lock = '0;
  endtask

  task automatic drive(input int m, input bit we, input bit lk, input logic [AW-1:0] a);
    m_req[m] = 1'b1;
    m_we[m]  = we;
    m_lock[m] = lk;
    m_addr[m*AW +: AW] = a;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_addr  = '0;
    m_wdata = {$urandom, $urandom, $urandom};
    s_rdata = {$urandom, $urandom, $urandom, $urandom};

    // reset with a read request pending
    drive(0, 1'b0, 1'b0, 32'h0000_4010);
    repeat (2) begin
      pre(); chk("rst_fp_gnt", f_gnt, 3'b000); post();
    end
    rst = 1'b0;

    // decode hit on slave 1
    idle(); drive(0, 1'b0, 1'b0, 32'h0000_4010);
    pre(); chk("dec_re", s_re, 4'b0010); chk("dec_addr", s_addr[63:32], 32'h10); post();
    idle();
    pre(); chk("dec_rv", m_rvalid, 3'b001); chk("dec_rd", m_rdata, s_rdata[63:32]); post();

    // unmapped write
    drive(0, 1'b1, 1'b0, 32'h3000_0000); m_wdata[31:0] = 32'hDEAD_BEEF;
    pre(); chk("miss_we", s_we, 4'b0000); chk("miss_gnt", m_gnt, 3'b001); post();
    idle();
    pre(); chk("miss_rv", m_rvalid, 3'b001); chk("miss_err", m_rerr, 3'b001); post();

    // round-robin fairness from reset, fixed priority alongside
    rst = 1'b1; pre(); post(); rst = 1'b0;
    m_req = 3'b111; m_we = 3'b000; m_lock = 3'b000;
    m_addr = {32'h2000_0000, 32'h1000_0000, 32'h0000_4000};
    for (int i = 0; i < 6; i++) begin
      pre();
      chk("rr_gnt", m_gnt, 3'b001 << (i % 3));
      if (i < 3) chk("fp_gnt", f_gnt, 3'b001);
      post();
    end

    // back-to-back reads by M1: uart then gpio
    idle(); drive(1, 1'b0, 1'b0, 32'h1000_0004);
    pre(); chk("pipe_g0", m_gnt, 3'b010); chk("pipe_re0", s_re, 4'b0100); post();
    m_addr[63:32] = 32'h2000_0008;
    pre();
    chk("pipe_rv0", m_rvalid, 3'b010); chk("pipe_rd0", m_rdata, s_rdata[95:64]);
    chk("pipe_re1", s_re, 4'b1000);
    post();
    idle();
    pre(); chk("pipe_rv1", m_rvalid, 3'b010); chk("pipe_rd1", m_rdata, s_rdata[127:96]); post();

    // lock bound: M2 locks, M0 waits for LOCK_MAX grants
    drive(2, 1'b0, 1'b1, 32'h0000_0100);
    pre(); chk("lk_g0", m_gnt, 3'b100); post();
    drive(0, 1'b0, 1'b0, 32'h0000_4000);
    for (int i = 0; i < 3; i++) begin
      pre(); chk("lk_hold", m_gnt, 3'b100); post();
    end
    pre(); chk("lk_rel", m_gnt, 3'b001); post();

    // reset in the read grant cycle
    idle(); drive(1, 1'b0, 1'b0, 32'h0000_4000);
    pre(); post();
    idle(); drive(0, 1'b0, 1'b0, 32'h0000_4010); rst = 1'b1;
    pre(); chk("mr_gnt", m_gnt, 3'b000); chk("mr_re0", s_re, 4'b0000); post();
    rst = 1'b0; idle();
    pre(); chk("mr_rv", m_rvalid, 3'b000); chk("mr_rd", m_rdata, 32'h0); chk("mr_re1", s_re, 4'b0000); post();
    m_req = 3'b111;
    pre(); chk("mr_ptr", m_gnt, 3'b001); post();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 49) == 0);
      m_req  = NM'($urandom);
      m_we   = NM'($urandom);
      m_lock = NM'($urandom);
      for (int m = 0; m < NM; m++) begin
        m_addr[m*AW +: AW]  = raddr();
        m_wdata[m*DW +: DW] = $urandom;
      end
      pre(); post();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
